// File: rtl/hazard_controller.sv
// hazard_controller
//   Central pipeline hazard unit. Produces Execute-stage forwarding selects,
//   the stall/flush controls for the fetch, decode and execute pipeline
//   registers, and sequences multi-cycle multiplies with a two-state FSM.
//   It also exports saturating stall/flush event counters for performance debug.
//
// Ports
//   CLK, RESET            clock (rising edge), synchronous active-high reset
//   RA1D, RA2D            Decode source register addresses
//   RA1E, RA2E, WA3E      Execute source and destination register addresses
//   WA3M, WA3W            Memory and Writeback destination register addresses
//   RegWE, RegWM, RegWW   register-write flags for Execute, Memory and Writeback
//   MemtoRegE             the Execute instruction is a load
//   PCSD, PCSE, PCSM      the Decode, Execute or Memory instruction writes the PC
//   BranchTakenE          a branch resolved taken in Execute
//   MulStartE             a multiply is present in Execute
//   ForwardAE, ForwardBE  operand selects: 00 regfile, 01 Writeback, 10 Memory
//   StallF, StallD        hold the PC and the fetch/decode register
//   FlushD, FlushE        clear the fetch/decode and decode/execute registers
//   MulBusy, MulDone      multiply in progress, and its last (result) cycle
//   StallCount            number of cycles with StallD=1 (saturating)
//   FlushCount            number of cycles with FlushE=1 (saturating)
module hazard_controller #(
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [3:0]       RA1D,
   input  logic [3:0]       RA2D,
   input  logic [3:0]       RA1E,
   input  logic [3:0]       RA2E,
   input  logic [3:0]       WA3E,
   input  logic [3:0]       WA3M,
   input  logic [3:0]       WA3W,
   input  logic             RegWE,
   input  logic             RegWM,
   input  logic             RegWW,
   input  logic             MemtoRegE,
   input  logic             PCSD,
   input  logic             PCSE,
   input  logic             PCSM,
   input  logic             BranchTakenE,
   input  logic             MulStartE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic             MulBusy,
   output logic             MulDone,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mul_state_t;

   // The counter is loaded with the number of BUSY cycles that follow the start cycle.
   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   mul_state_t state_r;
   mul_state_t state_next_s;
   logic [3:0] cnt_r;
   logic [3:0] cnt_next_s;
   logic       ldr_stall_s;
   logic       pc_pend_s;
   logic       mul_hold_s;

   // The Memory stage is younger than Writeback, so it wins when both match.
   // Register 15 is the PC and is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                          input logic       regwm,
                                          input logic [3:0] wa3m,
                                          input logic       regww,
                                          input logic [3:0] wa3w);
      logic [1:0] sel;
      if (regwm && (wa3m == ra) && (ra != 4'd15)) begin
         sel = 2'b10;
      end else if (regww && (wa3w == ra) && (ra != 4'd15)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Forwarding selects for both Execute operands.
   always_comb begin
      ForwardAE = fwd_sel(RA1E, RegWM, WA3M, RegWW, WA3W);
      ForwardBE = fwd_sel(RA2E, RegWM, WA3M, RegWW, WA3W);
   end

   // Hazard detection and the stall/flush controls.
   // A multiply keeps its operands internally, so Execute is filled with bubbles while it runs.
   always_comb begin
      ldr_stall_s = MemtoRegE && RegWE && ((RA1D == WA3E) || (RA2D == WA3E));
      pc_pend_s   = PCSD | PCSE | PCSM;
      mul_hold_s  = ((state_r == IDLE) && MulStartE) || (state_r == BUSY);
      StallF      = ldr_stall_s | pc_pend_s | mul_hold_s;
      StallD      = ldr_stall_s | mul_hold_s;
      FlushD      = pc_pend_s | BranchTakenE;
      FlushE      = ldr_stall_s | BranchTakenE | mul_hold_s;
      MulBusy     = (state_r == BUSY);
      MulDone     = (state_r == BUSY) && (cnt_r == 4'd1);
   end

   // Multiply FSM next-state logic. A MulStartE seen while BUSY cannot occur and is ignored.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (MulStartE) begin
               state_next_s = BUSY;
               cnt_next_s   = MUL_LOAD;
            end else begin
               state_next_s = IDLE;
               cnt_next_s   = cnt_r;
            end
         end
         BUSY: begin
            cnt_next_s = cnt_r - 4'd1;
            if (cnt_r == 4'd1) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = BUSY;
            end
         end
         default: begin
            state_next_s = IDLE;
            cnt_next_s   = 4'd0;
         end
      endcase
   end

   // Multiply FSM state register. Reset aborts any multiply in progress.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Saturating performance counters for stall and flush cycles.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         StallCount <= CNT_ZERO;
         FlushCount <= CNT_ZERO;
      end else begin
         if (StallD && (StallCount != CNT_MAX)) begin
            StallCount <= StallCount + CNT_ONE;
         end else begin
            StallCount <= StallCount;
         end
         if (FlushE && (FlushCount != CNT_MAX)) begin
            FlushCount <= FlushCount + CNT_ONE;
         end else begin
            FlushCount <= FlushCount;
         end
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

   localparam int MUL   = 4;
   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic CLK;
   logic RESET;
   logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
   logic RegWE, RegWM, RegWW, MemtoRegE, PCSD, PCSE, PCSM, BranchTakenE, MulStartE;
   logic [1:0] ForwardAE, ForwardBE;
   logic StallF, StallD, FlushD, FlushE, MulBusy, MulDone;
   logic [CNT_W-1:0] StallCount, FlushCount;

   hazard_controller #(.MUL_CYCLES(MUL), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RESET(RESET),
      .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWE(RegWE), .RegWM(RegWM), .RegWW(RegWW), .MemtoRegE(MemtoRegE),
      .PCSD(PCSD), .PCSE(PCSE), .PCSM(PCSM),
      .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .MulBusy(MulBusy), .MulDone(MulDone),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Reference model: cycle index, cycle in which the running multiply started,
   // and the two event totals (capped at all-ones).
   int cyc       = 0;
   int mul_start = -100;
   int m_stall   = 0;
   int m_flush   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // A multiply started in cycle s occupies Execute in s..s+MUL-1 and is BUSY in s+1..s+MUL-1.
   function automatic bit m_busy();
      return (cyc > mul_start) && (cyc <= mul_start + MUL - 1);
   endfunction

   function automatic bit m_done();
      return cyc == mul_start + MUL - 1;
   endfunction

   function automatic logic [1:0] m_fwd(input logic [3:0] ra);
      if (RegWM && WA3M == ra && ra != 4'd15) return 2'b10;
      if (RegWW && WA3W == ra && ra != 4'd15) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit m_ldr();
      return MemtoRegE && RegWE && (RA1D == WA3E || RA2D == WA3E);
   endfunction

   function automatic bit m_hold();
      return m_busy() || MulStartE;
   endfunction

   function automatic bit m_pcp();
      return PCSD || PCSE || PCSM;
   endfunction

   // Advance the reference model on each rising edge.
   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (RESET) begin
         mul_start <= -100;
         m_stall   <= 0;
         m_flush   <= 0;
      end else begin
         if (!m_busy() && MulStartE) mul_start <= cyc;
         if ((m_ldr() || m_hold()) && m_stall < CMAX) m_stall <= m_stall + 1;
         if ((m_ldr() || BranchTakenE || m_hold()) && m_flush < CMAX) m_flush <= m_flush + 1;
      end
   end

   // Compare every output against the model in the middle of each cycle.
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("ForwardAE", ForwardAE, m_fwd(RA1E));
         chk("ForwardBE", ForwardBE, m_fwd(RA2E));
         chk("StallF", StallF, m_ldr() || m_pcp() || m_hold());
         chk("StallD", StallD, m_ldr() || m_hold());
         chk("FlushD", FlushD, m_pcp() || BranchTakenE);
         chk("FlushE", FlushE, m_ldr() || BranchTakenE || m_hold());
         chk("MulBusy", MulBusy, m_busy());
         chk("MulDone", MulDone, m_done());
         chk("StallCount", StallCount, m_stall);
         chk("FlushCount", FlushCount, m_flush);
      end
   end

   task automatic clear_inputs();
      RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
      WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
      RegWE = 1'b0; RegWM = 1'b0; RegWW = 1'b0; MemtoRegE = 1'b0;
      PCSD = 1'b0; PCSE = 1'b0; PCSM = 1'b0;
      BranchTakenE = 1'b0; MulStartE = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      RESET = 1'b1;
      next_cycle();
      RESET = 1'b0;
   endtask

   function automatic logic [3:0] rand_reg();
      logic [3:0] r;
      if ($urandom_range(0, 1) == 0) r = 4'($urandom_range(0, 3));
      else r = 4'($urandom_range(0, 15));
      return r;
   endfunction

   initial begin
      clear_inputs();
      RESET = 1'b1;
      next_cycle();
      next_cycle();
      RESET = 1'b0;
      chk_en = 1'b1;

      // All inputs zero after reset: every output zero.
      @(negedge CLK);
      chk("rst_ForwardAE", ForwardAE, 2'b00);
      chk("rst_StallF", StallF, 1'b0);
      chk("rst_FlushD", FlushD, 1'b0);
      chk("rst_MulBusy", MulBusy, 1'b0);
      chk("rst_StallCount", StallCount, 4'd0);
      chk("rst_FlushCount", FlushCount, 4'd0);

      // Forwarding priority: Memory over Writeback, register 15 never forwarded.
      next_cycle();
      RegWM = 1'b1; WA3M = 4'd3; RegWW = 1'b1; WA3W = 4'd3; RA1E = 4'd3; RA2E = 4'd15;
      @(negedge CLK);
      chk("fwd_A_mem", ForwardAE, 2'b10);
      chk("fwd_B_r15", ForwardBE, 2'b00);
      next_cycle();
      RegWM = 1'b0;
      @(negedge CLK);
      chk("fwd_A_wb", ForwardAE, 2'b01);

      // Load-use stall for one cycle.
      next_cycle();
      clear_inputs();
      MemtoRegE = 1'b1; RegWE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
      @(negedge CLK);
      chk("ldr_StallF", StallF, 1'b1);
      chk("ldr_StallD", StallD, 1'b1);
      chk("ldr_FlushE", FlushE, 1'b1);
      chk("ldr_FlushD", FlushD, 1'b0);
      next_cycle();
      clear_inputs();
      @(negedge CLK);
      chk("ldr_StallCount", StallCount, 4'd1);
      chk("ldr_FlushCount", FlushCount, 4'd1);

      // Taken branch with a PC write in Execute.
      next_cycle();
      BranchTakenE = 1'b1; PCSE = 1'b1;
      @(negedge CLK);
      chk("br_FlushD", FlushD, 1'b1);
      chk("br_FlushE", FlushE, 1'b1);
      chk("br_StallF", StallF, 1'b1);
      chk("br_StallD", StallD, 1'b0);

      // Multiply started in cycle T (k = 0).
      next_cycle();
      do_reset();
      MulStartE = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         @(negedge CLK);
         chk("mul_StallD", StallD, (k <= 3) ? 1'b1 : 1'b0);
         chk("mul_MulBusy", MulBusy, (k >= 1 && k <= 3) ? 1'b1 : 1'b0);
         chk("mul_MulDone", MulDone, (k == 3) ? 1'b1 : 1'b0);
         if (k == 4) begin
            chk("mul_StallCount", StallCount, 4'd4);
            chk("mul_FlushE_end", FlushE, 1'b0);
         end
         next_cycle();
         MulStartE = 1'b0;
      end

      // Reset in the middle of a multiply, then an immediate new start.
      do_reset();
      MulStartE = 1'b1;
      next_cycle();
      MulStartE = 1'b0;
      next_cycle();
      RESET = 1'b1;
      next_cycle();
      RESET = 1'b0;
      MulStartE = 1'b1;
      @(negedge CLK);
      chk("abort_MulBusy", MulBusy, 1'b0);
      chk("abort_StallCount", StallCount, 4'd0);
      chk("abort_FlushCount", FlushCount, 4'd0);
      next_cycle();
      MulStartE = 1'b0;
      @(negedge CLK);
      chk("restart_MulBusy", MulBusy, 1'b1);
      chk("restart_StallCount", StallCount, 4'd1);
      repeat (4) next_cycle();

      // Saturation: 19 consecutive stall cycles.
      do_reset();
      MemtoRegE = 1'b1; RegWE = 1'b1; WA3E = 4'd5; RA1D = 4'd5;
      repeat (19) next_cycle();
      @(negedge CLK);
      chk("sat_StallCount", StallCount, 4'hF);
      chk("sat_FlushCount", FlushCount, 4'hF);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         next_cycle();
         RESET        = ($urandom_range(0, 63) == 0);
         RA1D         = rand_reg();
         RA2D         = rand_reg();
         RA1E         = rand_reg();
         RA2E         = rand_reg();
         WA3E         = rand_reg();
         WA3M         = rand_reg();
         WA3W         = rand_reg();
         RegWE        = 1'($urandom_range(0, 1));
         RegWM        = 1'($urandom_range(0, 1));
         RegWW        = 1'($urandom_range(0, 1));
         MemtoRegE    = 1'($urandom_range(0, 1));
         PCSD         = ($urandom_range(0, 7) == 0);
         PCSE         = ($urandom_range(0, 7) == 0);
         PCSM         = ($urandom_range(0, 7) == 0);
         BranchTakenE = ($urandom_range(0, 7) == 0);
         MulStartE    = !m_busy() && ($urandom_range(0, 5) == 0);
         if (MulStartE) MemtoRegE = 1'b0;
      end

      next_cycle();
      clear_inputs();
      @(negedge CLK);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
